// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin over NUM_REQ writeback
// sources, one registered write per cycle, r0 writes dropped, and a
// per-requester wait counter that flags starvation.

// Per-requester wait tracking: counts cycles spent pending without a grant.
module regfile_wait_lane #(
   parameter int WCW      = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic clrn,
   input  logic ena,
   input  logic req,
   input  logic gnt,
   output logic starve
);
   localparam logic [WCW-1:0] MW = WCW'(MAX_WAIT);

   logic [WCW-1:0] cnt, cnt_nxt;

   // Clear on grant or idle, otherwise count up and saturate at all-ones.
   always_comb begin
      cnt_nxt = cnt;
      if (!req || gnt)     cnt_nxt = '0;
      else if (cnt != '1)  cnt_nxt = cnt + WCW'(1);
   end

   // Counter and starve flag move together, so starve always matches the counter; frozen when ena=0.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt    <= '0;
         starve <= 1'b0;
      end else if (ena) begin
         cnt    <= cnt_nxt;
         starve <= (cnt_nxt >= MW);
      end
   end
endmodule

module regfile_write_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 15,
   parameter int WCW      = 4
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic                  ena,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  wr_en,
   output logic [AW-1:0]         wr_addr,
   output logic [DW-1:0]         wr_data,
   output logic                  zero_drop,
   output logic [NUM_REQ-1:0]    starve
);
   localparam int           PW = $clog2(NUM_REQ);
   localparam logic [PW:0]  NR = (PW+1)'(NUM_REQ);

   logic [NUM_REQ-1:0][AW-1:0] addr_a;
   logic [NUM_REQ-1:0][DW-1:0] data_a;
   logic [PW-1:0]              rr_ptr;
   logic [NUM_REQ-1:0]         elig;
   logic [2*NUM_REQ-1:0]       rot;
   logic                       win_vld;
   logic [PW-1:0]              win_off, win_idx, ptr_nxt;
   logic [PW:0]                win_sum;

   assign addr_a = req_addr;
   assign data_a = req_data;

   // A requester granted this cycle still shows its old req; exclude it so it is not served twice.
   assign elig = req & ~gnt;
   assign rot  = {elig, elig} >> rr_ptr;

   // First eligible requester at or after rr_ptr (offset into the rotated vector, then wrap back).
   always_comb begin
      win_vld = 1'b0;
      win_off = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (rot[k]) begin
            win_vld = 1'b1;
            win_off = PW'(k);
         end
      end
      win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
      if (win_sum >= NR) win_sum = win_sum - NR;
      win_idx = win_sum[PW-1:0];
      ptr_nxt = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
   end

   // Registered grant and write port; address/data hold when nothing wins.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         gnt       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         zero_drop <= 1'b0;
         rr_ptr    <= '0;
      end else if (ena && win_vld) begin
         gnt       <= NUM_REQ'(1) << win_idx;
         wr_addr   <= addr_a[win_idx];
         wr_data   <= data_a[win_idx];
         wr_en     <= |addr_a[win_idx];
         zero_drop <= ~|addr_a[win_idx];
         rr_ptr    <= ptr_nxt;
      end else begin
         gnt       <= '0;
         wr_en     <= 1'b0;
         zero_drop <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      regfile_wait_lane #(.WCW(WCW), .MAX_WAIT(MAX_WAIT)) u_lane (
         .clk    (clk),
         .clrn   (clrn),
         .ena    (ena),
         .req    (req[g]),
         .gnt    (gnt[g]),
         .starve (starve[g])
      );
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-free arithmetic reference model.
module tb_regfile_write_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0, clrn = 1'b0, ena = 1'b0;
   logic [N-1:0]         req = '0;
   logic [N-1:0][AW-1:0] ta  = '0;
   logic [N-1:0][DW-1:0] td  = '0;

   logic [N-1:0]  gnt, starve, gnt2, starve2, prev_gnt;
   logic          wr_en, zero_drop, wr_en2, zero_drop2;
   logic [AW-1:0] wr_addr, wr_addr2;
   logic [DW-1:0] wr_data, wr_data2;

   regfile_write_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .clrn(clrn), .ena(ena), .req(req), .req_addr(ta), .req_data(td),
      .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .zero_drop(zero_drop), .starve(starve));

   regfile_write_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_WAIT(2)) dut2 (
      .clk(clk), .clrn(clrn), .ena(ena), .req(req), .req_addr(ta), .req_data(td),
      .gnt(gnt2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .zero_drop(zero_drop2), .starve(starve2));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // reference model state
   int            m_gnt, m_ptr;
   int            m_wait [N];
   logic          m_wren, m_zd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_gnt();
      return (m_gnt < 0) ? '0 : N'(1 << m_gnt);
   endfunction

   function automatic logic [N-1:0] exp_starve(input int lim);
      logic [N-1:0] s = '0;
      for (int j = 0; j < N; j++) s[j] = (m_wait[j] >= lim);
      return s;
   endfunction

   task automatic model_reset();
      m_gnt = -1; m_ptr = 0; m_wren = 0; m_zd = 0; m_addr = '0; m_data = '0;
      for (int j = 0; j < N; j++) m_wait[j] = 0;
   endtask

   // Advance one clock with current inputs, update model, compare everything.
   task automatic step();
      int ng;
      prev_gnt = gnt;
      if (ena) begin
         for (int j = 0; j < N; j++) begin
            if (!req[j] || m_gnt == j) m_wait[j] = 0;
            else if (m_wait[j] < 15)   m_wait[j]++;
         end
         ng = -1;
         for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (ng < 0 && req[j] && m_gnt != j) ng = j;
         end
         if (ng >= 0) begin
            m_addr = ta[ng]; m_data = td[ng];
            m_wren = (ta[ng] != 0); m_zd = (ta[ng] == 0);
            m_ptr  = (ng + 1) % N;
         end else begin
            m_wren = 0; m_zd = 0;
         end
         m_gnt = ng;
      end else begin
         m_gnt = -1; m_wren = 0; m_zd = 0;
      end
      @(posedge clk); #1;
      chk("gnt",       gnt,       exp_gnt());
      chk("wr_en",     wr_en,     m_wren);
      chk("zero_drop", zero_drop, m_zd);
      chk("wr_addr",   wr_addr,   m_addr);
      chk("wr_data",   wr_data,   m_data);
      chk("starve",    starve,    exp_starve(15));
      chk("starve2",   starve2,   exp_starve(2));
      chk("dut2_port", {gnt2, wr_en2, wr_addr2, wr_data2, zero_drop2},
                       {exp_gnt(), m_wren, m_addr, m_data, m_zd});
      chk("b2b",       gnt & prev_gnt, 0);
   endtask

   // Assert reset mid-cycle; outputs must clear without any clock edge.
   task automatic async_reset();
      #2 clrn = 1'b0;
      #1;
      chk("rst_gnt",    gnt,       0);
      chk("rst_wr_en",  wr_en,     0);
      chk("rst_zd",     zero_drop, 0);
      chk("rst_starve", {starve, starve2}, 0);
      chk("rst_addr",   {wr_addr, wr_data}, 0);
      model_reset();
      #1 clrn = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      async_reset();

      // lone request, then reset while the write is in flight
      ena = 1; req = 3'b010; ta[1] = 5'd3; td[1] = 32'hDEADBEEF;
      step();
      chk("t1_wr_en_pre", wr_en, 1);
      async_reset();
      step();
      chk("t1_gnt", gnt, 3'b010);
      chk("t1_addr", wr_addr, 5'd3);
      req = '0; step();

      // full contention, reqs held through grant cycles
      async_reset();
      req = 3'b111; ta[0] = 5'd1; ta[1] = 5'd2; ta[2] = 5'd3;
      for (int j = 0; j < N; j++) td[j] = $urandom;
      step(); chk("t2_first", gnt, 3'b001);
      step(); chk("t2_second", gnt, 3'b010);
      repeat (7) step();

      // single stale requester
      async_reset();
      req = 3'b001; ta[0] = 5'd4;
      repeat (6) step();

      // write to r0 is dropped, pointer wraps to 0
      async_reset();
      req = 3'b100; ta[2] = 5'd0; td[2] = 32'h1234;
      step();
      chk("t4_zd", zero_drop, 1);
      chk("t4_wr_en", wr_en, 0);
      req = 3'b011; ta[0] = 5'd7; ta[1] = 5'd8;
      step();
      chk("t4_ptr_wrap", gnt, 3'b001);
      req = 3'b000; step();

      // freeze, then resume
      async_reset();
      ena = 0; req = 3'b010; ta[1] = 5'd9;
      repeat (20) step();
      ena = 1; step();
      chk("t5_resume", gnt, 3'b010);
      req = '0; step();

      // starvation with MAX_WAIT=2, then reset while starve is high
      async_reset();
      req = 3'b111;
      repeat (12) step();
      chk("t5_starve_seen", |starve2, 1);
      async_reset();

      // random traffic obeying the handshake
      req = '0;
      for (int c = 0; c < 400; c++) begin
         ena = ($urandom % 8) != 0;
         step();
         for (int j = 0; j < N; j++) begin
            if (!req[j] || m_gnt == j) begin
               req[j] = ($urandom % 3) != 0;
               ta[j]  = ($urandom % 6 == 0) ? '0 : AW'($urandom);
               td[j]  = $urandom;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
